// File: rtl/apb_mem_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mem_slave_if
//  Description : APB completer-side bus bundle for apb_mem_slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_mem_slave_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel,
    output penable,
    output pwrite,
    output paddr,
    output pwdata,
    input  prdata,
    input  pready,
    input  pslverr
  );

  modport slave (
    input  psel,
    input  penable,
    input  pwrite,
    input  paddr,
    input  pwdata,
    output prdata,
    output pready,
    output pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mem_slave
//  Description : APB completer fronting a word-addressed register memory,
//                with fixed wait states and PSLVERR on out-of-range access.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_mem_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  wire logic      pclk,
  input  wire logic      presetn,
  apb_mem_slave_if.slave apb
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] C_WAIT = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_err;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  w_setup;
  logic                  w_addr_err;
  logic                  w_mem_we;
  logic [IDX_W-1:0]      w_idx;

  assign w_setup    = apb.psel && !apb.penable;
  assign w_addr_err = (32'(apb.paddr) >= 32'(DEPTH));
  assign w_idx      = apb.paddr[IDX_W-1:0];

  // Write address is the live PADDR at the completing edge; range check was latched at setup.
  assign w_mem_we = (r_state == ACCESS) && apb.psel && apb.penable &&
                    (r_cnt == 4'd0) && r_wr && !r_err;

  // PREADY/PSLVERR are registered so they always equal (ACCESS && cnt == 0) of the same cycle.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_err     <= 1'b0;
      r_wr      <= 1'b0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_state   <= ACCESS;
            r_cnt     <= C_WAIT;
            r_err     <= w_addr_err;
            r_wr      <= apb.pwrite;
            r_pready  <= (C_WAIT == 4'd0);
            r_pslverr <= (C_WAIT == 4'd0) && w_addr_err;
            if (!apb.pwrite) begin
              r_prdata <= w_addr_err ? '0 : mem[w_idx];
            end
          end
        end
        ACCESS: begin
          if (!apb.psel) begin
            r_state   <= IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
          end else if (apb.penable) begin
            if (r_cnt != 4'd0) begin
              r_cnt     <= r_cnt - 4'd1;
              r_pready  <= (r_cnt == 4'd1);
              r_pslverr <= (r_cnt == 4'd1) && r_err;
            end else begin
              r_state   <= IDLE;
              r_pready  <= 1'b0;
              r_pslverr <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (w_mem_we) begin
      mem[w_idx] <= apb.pwdata;
    end
  end

  assign apb.prdata  = r_prdata;
  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_mem_slave
//  Description : Scoreboard bench driving four differently configured slaves.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          sel = 0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  logic [31:0] last_rd [4];

  always #5 clk = ~clk;

  apb_mem_slave_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8))  bus0 ();
  apb_mem_slave_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8))  bus1 ();
  apb_mem_slave_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8))  bus2 ();
  apb_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus3 ();

  assign bus0.psel = psel && (sel == 0);
  assign bus1.psel = psel && (sel == 1);
  assign bus2.psel = psel && (sel == 2);
  assign bus3.psel = psel && (sel == 3);
  assign bus0.penable = penable;
  assign bus1.penable = penable;
  assign bus2.penable = penable;
  assign bus3.penable = penable;
  assign bus0.pwrite = pwrite;
  assign bus1.pwrite = pwrite;
  assign bus2.pwrite = pwrite;
  assign bus3.pwrite = pwrite;
  assign bus0.paddr = paddr[7:0];
  assign bus1.paddr = paddr[7:0];
  assign bus2.paddr = paddr[7:0];
  assign bus3.paddr = paddr;
  assign bus0.pwdata = pwdata[7:0];
  assign bus1.pwdata = pwdata[7:0];
  assign bus2.pwdata = pwdata[7:0];
  assign bus3.pwdata = pwdata;

  apb_mem_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(64), .WAIT_STATES(0)) u_dut0 (
    .pclk(clk), .presetn(rst_n), .apb(bus0));
  apb_mem_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(64), .WAIT_STATES(3)) u_dut1 (
    .pclk(clk), .presetn(rst_n), .apb(bus1));
  apb_mem_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(64), .WAIT_STATES(2)) u_dut2 (
    .pclk(clk), .presetn(rst_n), .apb(bus2));
  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(1024), .WAIT_STATES(1)) u_dut3 (
    .pclk(clk), .presetn(rst_n), .apb(bus3));

  always_comb begin
    prdata_o  = 32'h0;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    case (sel)
      0: begin prdata_o = {24'h0, bus0.prdata}; pready_o = bus0.pready; pslverr_o = bus0.pslverr; end
      1: begin prdata_o = {24'h0, bus1.prdata}; pready_o = bus1.pready; pslverr_o = bus1.pslverr; end
      2: begin prdata_o = {24'h0, bus2.prdata}; pready_o = bus2.pready; pslverr_o = bus2.pslverr; end
      default: begin prdata_o = bus3.prdata; pready_o = bus3.pready; pslverr_o = bus3.pslverr; end
    endcase
  end

  function automatic int dut_ws(input int s);
    case (s)
      0: return 0;
      1: return 3;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int dut_depth(input int s);
    return (s == 3) ? 1024 : 64;
  endfunction

  function automatic logic [31:0] dut_mask(input int s);
    return (s == 3) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s (dut %0d): got 0x%0h expected 0x%0h at %0t", tag, sel, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer; expectations are queued at drive time and popped at PREADY.
  task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    exp_t g;
    int   n;
    int   key;
    key    = sel * 4096 + int'(a);
    e.wr   = wr;
    e.err  = (int'(a) >= dut_depth(sel));
    e.lat  = dut_ws(sel);
    e.data = last_rd[sel];
    if (!wr) begin
      e.data = 32'h0;
      if (!e.err && model.exists(key)) e.data = model[key];
      last_rd[sel] = e.data;
    end else if (!e.err) begin
      model[key] = d & dut_mask(sel);
    end
    sb.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    tick();
    if (!wr) check("rd_early", prdata_o, e.data);
    penable = 1'b1;
    n = 0;
    while (!pready_o && n < 20) begin
      tick();
      n++;
    end
    g = sb.pop_front();
    if (!pready_o) begin
      check("pready_timeout", 32'(n), 32'(g.lat));
    end else begin
      check("latency", 32'(n), 32'(g.lat));
      check("pslverr", 32'(pslverr_o), 32'(g.err));
      check(g.wr ? "wr_prdata_hold" : "rdata", prdata_o, g.data);
    end
    tick();
    psel = 1'b0; penable = 1'b0;
    check("pready_pulse", 32'(pready_o), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) last_rd[i] = 32'h0;

    // Reset with random bus activity.
    for (int i = 0; i < 3; i++) begin
      psel = 1'($urandom); penable = 1'($urandom); pwrite = 1'($urandom);
      paddr = 12'($urandom); pwdata = $urandom;
      tick();
      check("rst_prdata0", {24'h0, bus0.prdata}, 32'h0);
      check("rst_pready0", 32'(bus0.pready), 32'h0);
      check("rst_pslverr3", 32'(bus3.pslverr), 32'h0);
      check("rst_prdata3", bus3.prdata, 32'h0);
    end
    psel = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_pready", 32'(pready_o), 32'h0);

    sel = 0;
    xfer(1'b1, 12'h010, 32'hA5);
    xfer(1'b0, 12'h010, 32'h0);

    sel = 1;
    xfer(1'b1, 12'h03F, 32'h5A);
    xfer(1'b0, 12'h03F, 32'h0);

    sel = 0;
    xfer(1'b1, 12'h000, 32'h11);
    xfer(1'b1, 12'h040, 32'hFF);
    xfer(1'b0, 12'h040, 32'h0);
    xfer(1'b0, 12'h000, 32'h0);

    // Access phase without a setup phase must be ignored.
    xfer(1'b1, 12'h020, 32'h33);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h020; pwdata = 32'h99;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("violation_pready", 32'(pready_o), 32'h0);
    end
    psel = 1'b0; penable = 1'b0;
    tick();
    xfer(1'b0, 12'h020, 32'h0);

    // Aborted write.
    sel = 2;
    xfer(1'b1, 12'h005, 32'h22);
    xfer(1'b0, 12'h005, 32'h0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h005; pwdata = 32'h77;
    tick();
    penable = 1'b1;
    tick();
    check("abort_pready", 32'(pready_o), 32'h0);
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_idle", 32'(pready_o), 32'h0);
    end
    xfer(1'b0, 12'h005, 32'h0);

    // Reset pulsed mid-access.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h005; pwdata = 32'h77;
    tick();
    penable = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_prdata", prdata_o, 32'h0);
    check("midrst_pready", 32'(pready_o), 32'h0);
    check("midrst_pslverr", 32'(pslverr_o), 32'h0);
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) last_rd[i] = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    xfer(1'b0, 12'h005, 32'h0);

    sel = 3;
    xfer(1'b1, 12'h3FF, 32'hDEADBEEF);
    xfer(1'b0, 12'h3FF, 32'h0);
    xfer(1'b1, 12'h400, 32'h1234_5678);
    xfer(1'b0, 12'h400, 32'h0);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB completer that fronts a word-addressed register memory on the peripheral bus. Generalises the team's first 8-bit/64-entry slave: width, depth and a fixed number of wait states are parameters. It adds a registered read path, a proper access-phase FSM, and PSLVERR for out-of-range addresses. It sits behind the APB bridge/decoder, one instance per PSEL line.

## Interface
- DATA_WIDTH, 8, width of PWDATA/PRDATA and of each memory word
- ADDR_WIDTH, 8, width of PADDR; word index, no byte offset bits
- DEPTH, 64, number of memory words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH
- WAIT_STATES, 0, extra access-phase cycles before PREADY; legal range 0..15

- PCLK  in  1  bus clock; all state changes on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- PSEL  in  1  slave select from decoder
- PENABLE  in  1  APB access-phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  word address
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data, registered
- PREADY  out  1  transfer-complete strobe
- PSLVERR  out  1  error response, valid only while PREADY = 1

## Operation
- FSM states: IDLE, ACCESS. Counter cnt is 4 bits wide. Flags are captured at setup: err (PADDR >= DEPTH) and wr (PWRITE).
- IDLE: on an edge with PSEL=1 and PENABLE=0 (setup phase):
  - go to ACCESS;
  - load cnt = WAIT_STATES;
  - capture err and wr;
  - if read: PRDATA <= err ? 0 : mem[PADDR].
  - Other inputs are ignored. PSEL=1 and PENABLE=1 seen while in IDLE is a protocol violation: no write, PREADY stays 0.
- ACCESS, PSEL=1 and PENABLE=1:
  - if cnt != 0, cnt decrements by 1;
  - if cnt == 0, the transfer completes on this edge. If wr and not err, mem[PADDR] <= PWDATA. Next state is IDLE.
- ACCESS, PSEL=0 (aborted transfer): return to IDLE. No memory write. PRDATA is left unchanged.
- PREADY = (state == ACCESS) && (cnt == 0). This is decoded from registers only, with no combinational path from inputs.
- PSLVERR = PREADY && err. An out-of-range write leaves memory untouched. An out-of-range read returns PRDATA = 0.
- PRDATA holds its last value between reads. Writes never update PRDATA.
- Back-to-back transfers need a new setup phase (APB rule). The FSM always returns to IDLE after completion, so the next setup is accepted on the cycle after PREADY.
- PADDR, PWRITE and PWDATA are required stable from setup through completion. The block samples PADDR again at the completing write edge.
- Reset (asynchronous assert, synchronous-safe deassert):
  - state = IDLE, cnt = 0, err = 0, wr = 0;
  - PRDATA = 0, PREADY = 0, PSLVERR = 0.
  - Memory contents are not reset and are undefined until written.
  - Reset asserted mid-transfer abandons the transfer immediately. No write occurs unless the completing edge preceded reset assertion.

## Timing
- Setup edge at T0. PREADY is high during cycle T0+1+WAIT_STATES. The transfer completes at the end of that cycle.
- Total transfer length is 2 + WAIT_STATES cycles (setup + access), matching APB3.
- For reads, PRDATA is valid from T0+1 onward, one full cycle or more before the completing edge.
- For writes, memory is updated at the completing edge. A read set up on the next cycle returns the new value.
- PREADY is high for exactly one cycle per completed transfer. It is never high in IDLE.

## Test plan
- Reset then idle bus: PRESETn low for 3 cycles with random inputs -> PRDATA=0, PREADY=0, PSLVERR=0 throughout. FSM leaves IDLE only after the first setup phase following deassert.
- WAIT_STATES=0, DEPTH=64: write 0xA5 to addr 0x10, then read addr 0x10 -> each PREADY high exactly 1 cycle after setup. Read returns PRDATA=0xA5. PSLVERR=0.
- WAIT_STATES=3: read addr 0x3F after writing 0x5A -> PREADY low for 3 access cycles and high on the 4th. PRDATA=0x5A from the first access cycle.
- Out of range, DEPTH=64: write 0xFF to addr 0x40, then read 0x40 and read 0x00 (pre-written 0x11) -> the first two transfers give PSLVERR=1 with PREADY, the error read gives PRDATA=0x00, and addr 0x00 still reads 0x11.
- Abort and reset: WAIT_STATES=2, drop PSEL after 1 access cycle of a write of 0x77 to 0x05 (previously 0x22) -> no PREADY, next read of 0x05 returns 0x22. Repeat with PRESETn pulsed mid-access -> same result, and all outputs are 0 during reset.
- Parameter sweep: DATA_WIDTH=32, ADDR_WIDTH=12, DEPTH=1024 -> write/read 0xDEADBEEF at 0x3FF passes with PSLVERR=0. Address 0x400 sets PSLVERR=1.
